icache: RTL
===========

# icache

Direct-mapped, one-word-per-line instruction cache between the instruction fetcher and `mem_ctrl`. It is the requester side of `mem_ctrl`'s instruction-read channel. On a hit it returns the instruction from local storage. On a miss it holds a fill request to `mem_ctrl` until the word arrives, writes the word into the array and forwards it to the fetcher. A `clear` from the ROB (branch mispredict) cancels delivery of any in-flight fetch but never aborts a fill, because `mem_ctrl` cannot abandon a started read.

## Interface
- `INDEX_BITS`, 8: number of index bits; the cache has `2^INDEX_BITS` lines of 32 bits each.
- `clk` in 1: system clock.
- `rst` in 1: synchronous reset, active-high.
- `rdy` in 1: global enable; while low every register holds its value.
- `clear` in 1: flush from the ROB; cancels the pending fetch.
- `fetch_valid` in 1: the fetcher requests the instruction at `fetch_pc`.
- `fetch_pc` in 32: fetch address, word-aligned; `[1:0]` is ignored.
- `inst_valid` out 1: one-cycle pulse; `inst` is valid in this cycle.
- `inst` out 32: instruction returned to the fetcher.
- `ic_valid` out 1: fill request to `mem_ctrl`.
- `ic_addr` out 32: fill address, `{fetch_pc[31:2], 2'b00}`.
- `ic_enable` in 1: `mem_ctrl` completion pulse.
- `ic_inst` in 32: fill data, valid only while `ic_enable` is high.

## Operation
- **Address split**
  - index = `pc[INDEX_BITS+1:2]`
  - tag = `pc[31:INDEX_BITS+2]`
  - hit = `valid[index] && tag_arr[index] == tag`
- **State IDLE**
  - If `clear` is high: the request is ignored and `inst_valid <= 0`.
  - Else, if `fetch_valid` is high and `inst_valid` is low: on a hit, `inst <= data[index]` and `inst_valid <= 1`. On a miss, `ic_valid <= 1`, `ic_addr <= {fetch_pc[31:2], 2'b00}`, latch the index and tag, `discard <= 0`, and go to MISS.
  - Requests are ignored in any cycle where `inst_valid` is high; the fetcher updates `fetch_pc` on that edge.
- **State MISS**
  - Hold `ic_valid = 1` and hold `ic_addr` stable. Dropping `ic_valid` would stall `mem_ctrl` permanently.
  - `clear` sets `discard <= 1`. Changes to `fetch_pc` and `fetch_valid` are ignored.
  - On `ic_enable`:
    - Write the latched index with `valid = 1`, the latched tag and `ic_inst`.
    - Set `ic_valid <= 0` and return to IDLE.
    - If `discard == 0` and `clear` is low in this cycle, set `inst <= ic_inst` and `inst_valid <= 1`; otherwise `inst_valid <= 0`.
- **Pulse rule:** `inst_valid` is high for exactly one cycle per delivered instruction and is cleared on the following edge.
- **Reset values**
  - All `valid` bits cleared; state = IDLE.
  - `ic_valid = 0`, `ic_addr = 0`, `inst_valid = 0`, `inst = 0`, `discard = 0`.
  - Reset mid-MISS drops the request immediately; `mem_ctrl` is reset by the same `rst`.
- **`rdy` low:** nothing changes; the array is not written, the state is held and all outputs hold their values.

## Timing
- **Hit:** request in cycle N → `inst_valid` high in N+1. The next request is accepted in N+2, giving a peak rate of one instruction per 2 cycles.
- **Miss:**
  - Request in cycle N → `ic_valid` high from N+1.
  - `inst_valid` follows in the cycle after `ic_enable` is sampled.
  - Latency is unbounded because `mem_ctrl` gives the store/load buffer priority. It is at least 6 cycles (one idle cycle, then 5 read cycles).
- **`ic_valid` release:** it falls on the edge that samples `ic_enable`. `mem_ctrl`'s mandatory idle cycle guarantees that no duplicate fill starts.
- **Line reuse:** a line refilled in cycle M is a hit for a request presented in M+1 or later.

## Structure
- **Shared header `utils.v`:** add the state encodings `IC_IDLE`/`IC_MISS` and the default for `INDEX_BITS`.
- **Sub-module `icache_array`:**
  - Storage for valid, tag and data.
  - Combinational read port: index in → hit and data out.
  - One synchronous write port.
  - Reset clears all valid bits.
- **`icache` itself:** the FSM, the latched index/tag registers and the `discard` flag.

## Test plan
- **Cold miss then hit**
  - Stimulus: `fetch_pc = 0x100` with `ic_inst = 0x00A00093` returned on `ic_enable`.
  - Required: `ic_addr = 0x100`; `inst_valid` returns `0x00A00093`. A refetch of `0x100` returns the same word in 1 cycle with `ic_valid` staying 0.
- **Conflict eviction:** with `INDEX_BITS = 8`, fetch `0x100` then `0x500` (same index), then `0x100` again → all three are misses and the third fill is re-requested at `0x100`.
- **Clear during MISS:** assert `clear` while `ic_valid` is high → no `inst_valid` pulse on `ic_enable`, but a later fetch of the same pc is a 1-cycle hit.
- **Long `mem_ctrl` stall:** hold `ic_enable` low for 50 cycles → `ic_valid` and `ic_addr` stay stable throughout, and exactly one fill is requested.
- **`rdy` low:** drop `rdy` for 3 cycles in the middle of a hit and in the middle of a miss → all outputs are frozen, and exactly one `inst_valid` pulse with the correct data appears after `rdy` returns.
- **Reset mid-MISS:** assert `rst` while `ic_valid` is high → `ic_valid = 0` next cycle, and a fetch of a previously cached pc misses.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared constants for the instruction cache: FSM encodings, default geometry
// and the fill-address helper.
package icache_pkg;

   localparam int unsigned INDEX_BITS_DEFAULT = 8;

   // FSM state encodings
   localparam logic [0:0] IC_IDLE = 1'b0;
   localparam logic [0:0] IC_MISS = 1'b1;

   // Word-aligned fill address for a fetch pc
   function automatic logic [31:0] line_addr(input logic [31:0] pc);
      return {pc[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/icache_if.sv
// Fetcher-side and mem_ctrl-side signals of the instruction cache.
// The cache uses the slave view; the fetcher/mem_ctrl side uses the master view.
interface icache_if;

   logic        clear;
   logic        fetch_valid;
   logic [31:0] fetch_pc;
   logic        inst_valid;
   logic [31:0] inst;
   logic        ic_valid;
   logic [31:0] ic_addr;
   logic        ic_enable;
   logic [31:0] ic_inst;

   modport slave (
      input  clear, fetch_valid, fetch_pc, ic_enable, ic_inst,
      output inst_valid, inst, ic_valid, ic_addr
   );

   modport master (
      output clear, fetch_valid, fetch_pc, ic_enable, ic_inst,
      input  inst_valid, inst, ic_valid, ic_addr
   );

endinterface

// File: rtl/icache_array.sv
// Valid/tag/data storage for the direct-mapped cache: combinational lookup,
// one synchronous write port, valid bits cleared by reset.
module icache_array
   import icache_pkg::*;
#(
   parameter  int unsigned INDEX_BITS = INDEX_BITS_DEFAULT,
   localparam int unsigned TAG_BITS   = 30 - INDEX_BITS,
   localparam int unsigned LINES      = 1 << INDEX_BITS
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [INDEX_BITS-1:0] rd_index_i,
   input  logic [TAG_BITS-1:0]   rd_tag_i,
   output logic                  rd_hit_o,
   output logic [31:0]           rd_data_o,
   input  logic                  wr_en_i,
   input  logic [INDEX_BITS-1:0] wr_index_i,
   input  logic [TAG_BITS-1:0]   wr_tag_i,
   input  logic [31:0]           wr_data_i
);

   logic [LINES-1:0]    valid_q, valid_d;
   logic [TAG_BITS-1:0] tag_mem  [LINES];
   logic [31:0]         data_mem [LINES];

   // Set the valid bit of the line being filled
   always_comb begin
      valid_d = valid_q;
      if (wr_en_i) begin
         valid_d[wr_index_i] = 1'b1;
      end
   end

   // Valid bits: the only storage that needs a reset value
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
      end else begin
         valid_q <= valid_d;
      end
   end

   // Tag and data payload; stale contents are masked by the valid bit
   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         tag_mem[wr_index_i]  <= wr_tag_i;
         data_mem[wr_index_i] <= wr_data_i;
      end
   end

   // Combinational lookup
   always_comb begin
      rd_hit_o  = valid_q[rd_index_i] && (tag_mem[rd_index_i] == rd_tag_i);
      rd_data_o = data_mem[rd_index_i];
   end

endmodule

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache. Hits answer the next
// cycle; misses hold a fill request to mem_ctrl until ic_enable. A clear only
// suppresses delivery: a started fill always completes and is written back.
module icache
   import icache_pkg::*;
#(
   parameter  int unsigned INDEX_BITS = INDEX_BITS_DEFAULT,
   localparam int unsigned TAG_BITS   = 30 - INDEX_BITS
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   rdy,
   icache_if.slave bus
);

   logic [0:0]            state_q, state_d;
   logic                  ic_valid_q, ic_valid_d;
   logic [31:0]           ic_addr_q, ic_addr_d;
   logic                  inst_valid_q, inst_valid_d;
   logic [31:0]           inst_q, inst_d;
   logic                  discard_q, discard_d;
   logic [INDEX_BITS-1:0] idx_q, idx_d;
   logic [TAG_BITS-1:0]   tag_q, tag_d;

   logic                  rd_hit;
   logic [31:0]           rd_data;
   logic                  arr_we;
   logic [INDEX_BITS-1:0] fetch_index;
   logic [TAG_BITS-1:0]   fetch_tag;

   assign fetch_index = bus.fetch_pc[INDEX_BITS+1:2];
   assign fetch_tag   = bus.fetch_pc[31:INDEX_BITS+2];

   icache_array #(
      .INDEX_BITS (INDEX_BITS)
   ) u_array (
      .clk        (clk),
      .rst        (rst),
      .rd_index_i (fetch_index),
      .rd_tag_i   (fetch_tag),
      .rd_hit_o   (rd_hit),
      .rd_data_o  (rd_data),
      .wr_en_i    (arr_we),
      .wr_index_i (idx_q),
      .wr_tag_i   (tag_q),
      .wr_data_i  (bus.ic_inst)
   );

   // FSM next state, fill request and one-cycle delivery pulse
   always_comb begin
      state_d      = state_q;
      ic_valid_d   = ic_valid_q;
      ic_addr_d    = ic_addr_q;
      inst_valid_d = inst_valid_q;
      inst_d       = inst_q;
      discard_d    = discard_q;
      idx_d        = idx_q;
      tag_d        = tag_q;
      arr_we       = 1'b0;
      // rdy low freezes everything, including the pulse and the array
      if (rdy) begin
         inst_valid_d = 1'b0;
         case (state_q)
            IC_IDLE: begin
               // a request in the pulse cycle is ignored: the fetcher moves on
               if (!bus.clear && bus.fetch_valid && !inst_valid_q) begin
                  if (rd_hit) begin
                     inst_d       = rd_data;
                     inst_valid_d = 1'b1;
                  end else begin
                     ic_valid_d = 1'b1;
                     ic_addr_d  = line_addr(bus.fetch_pc);
                     idx_d      = fetch_index;
                     tag_d      = fetch_tag;
                     discard_d  = 1'b0;
                     state_d    = IC_MISS;
                  end
               end
            end
            IC_MISS: begin
               if (bus.clear) begin
                  discard_d = 1'b1;
               end
               if (bus.ic_enable) begin
                  arr_we     = 1'b1;
                  ic_valid_d = 1'b0;
                  state_d    = IC_IDLE;
                  if (!discard_q && !bus.clear) begin
                     inst_d       = bus.ic_inst;
                     inst_valid_d = 1'b1;
                  end
               end
            end
            default: state_d = IC_IDLE;
         endcase
      end
   end

   // State registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IC_IDLE;
         ic_valid_q   <= 1'b0;
         ic_addr_q    <= '0;
         inst_valid_q <= 1'b0;
         inst_q       <= '0;
         discard_q    <= 1'b0;
         idx_q        <= '0;
         tag_q        <= '0;
      end else begin
         state_q      <= state_d;
         ic_valid_q   <= ic_valid_d;
         ic_addr_q    <= ic_addr_d;
         inst_valid_q <= inst_valid_d;
         inst_q       <= inst_d;
         discard_q    <= discard_d;
         idx_q        <= idx_d;
         tag_q        <= tag_d;
      end
   end

   assign bus.ic_valid   = ic_valid_q;
   assign bus.ic_addr    = ic_addr_q;
   assign bus.inst_valid = inst_valid_q;
   assign bus.inst       = inst_q;

endmodule
